// File: rtl/key_pkg.sv
// Shared key-handling definitions: one-hot gesture states, 100 MHz timing defaults
// and the debounce interval used by the upstream debouncer.
package key_pkg;

   typedef enum logic [4:0] {
      KS_IDLE   = 5'b00001,
      KS_PRESS1 = 5'b00010,
      KS_WAIT2  = 5'b00100,
      KS_PRESS2 = 5'b01000,
      KS_LONG   = 5'b10000
   } key_state_e;

   localparam int KEY_LONG_CYC_DEF    = 100_000_000;
   localparam int KEY_DBL_GAP_CYC_DEF = 30_000_000;
   localparam int KEY_REPEAT_CYC_DEF  = 20_000_000;
   localparam int KEY_DEBOUNCE_CYC    = 2_000_000;

   function automatic int key_max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/key_edge.sv
// Edge detector on the debounced key level: combinational rise/fall strobes for the
// gesture FSM and registered one-cycle press/release pulses.
module key_edge (
   input  logic clk,
   input  logic rst,
   input  logic key_level_i,
   output logic rise_o,
   output logic fall_o,
   output logic press_pulse_o,
   output logic release_pulse_o
);

   logic key_prev_q;
   logic press_q;
   logic release_q;

   assign rise_o = key_level_i & ~key_prev_q;
   assign fall_o = ~key_level_i & key_prev_q;

   // Resetting the history to 1 suppresses a phantom press for a key held through reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_prev_q <= 1'b1;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
      end else begin
         key_prev_q <= key_level_i;
         press_q    <= rise_o;
         release_q  <= fall_o;
      end
   end

   assign press_pulse_o   = press_q;
   assign release_pulse_o = release_q;

endmodule

// File: rtl/key_event.sv
// Gesture decoder (click / double click / long press) on a debounced key level.
// Define KEY_EVENT_REPEAT_EN to enable auto-repeat pulses while a long press is held.
module key_event
   import key_pkg::*;
#(
   parameter int LONG_CYC    = KEY_LONG_CYC_DEF,
   parameter int DBL_GAP_CYC = KEY_DBL_GAP_CYC_DEF,
   parameter int REPEAT_CYC  = KEY_REPEAT_CYC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic click,
   output logic dbl_click,
   output logic long_press,
   output logic repeat_pulse,
   output logic busy
);

   localparam int CNT_W = $clog2(key_max3(LONG_CYC, DBL_GAP_CYC, REPEAT_CYC));
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   generate
      if (LONG_CYC < 2 || DBL_GAP_CYC < 2 || REPEAT_CYC < 2) begin : g_param_check
         $error("key_event: LONG_CYC, DBL_GAP_CYC and REPEAT_CYC must all be >= 2");
      end
   endgenerate

   logic rise, fall;

   key_edge u_edge (
      .clk             (clk),
      .rst             (rst),
      .key_level_i     (key_level),
      .rise_o          (rise),
      .fall_o          (fall),
      .press_pulse_o   (press_pulse),
      .release_pulse_o (release_pulse)
   );

   key_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             click_q, click_d;
   logic             dbl_q, dbl_d;
   logic             long_q, long_d;
   logic             restart;
`ifdef KEY_EVENT_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
   logic rep_q, rep_d;
`endif

   // Edge conditions are tested before the counter thresholds so release/rise win ties.
   always_comb begin
      state_d = state_q;
      click_d = 1'b0;
      dbl_d   = 1'b0;
      long_d  = 1'b0;
      restart = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      rep_d   = 1'b0;
`endif
      unique case (state_q)
         KS_IDLE: begin
            if (rise) state_d = KS_PRESS1;
         end
         KS_PRESS1: begin
            if (fall) begin
               state_d = KS_WAIT2;
            end else if (key_level && cnt_q == LONG_LAST) begin
               long_d  = 1'b1;
               state_d = KS_LONG;
            end
         end
         KS_WAIT2: begin
            if (rise) begin
               state_d = KS_PRESS2;
            end else if (cnt_q == GAP_LAST) begin
               click_d = 1'b1;
               state_d = KS_IDLE;
            end
         end
         KS_PRESS2: begin
            if (fall) begin
               dbl_d   = 1'b1;
               state_d = KS_IDLE;
            end else if (key_level && cnt_q == LONG_LAST) begin
               long_d  = 1'b1;
               state_d = KS_LONG;
            end
         end
         KS_LONG: begin
            if (fall) begin
               state_d = KS_IDLE;
`ifdef KEY_EVENT_REPEAT_EN
            end else if (key_level && cnt_q == REP_LAST) begin
               rep_d   = 1'b1;
               restart = 1'b1;
`endif
            end
         end
         default: state_d = KS_IDLE;
      endcase

      if (state_d != state_q || restart) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= KS_IDLE;
         cnt_q   <= '0;
         click_q <= 1'b0;
         dbl_q   <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         click_q <= click_d;
         dbl_q   <= dbl_d;
         long_q  <= long_d;
      end
   end

`ifdef KEY_EVENT_REPEAT_EN
   always_ff @(posedge clk) begin
      if (rst) rep_q <= 1'b0;
      else     rep_q <= rep_d;
   end
   assign repeat_pulse = rep_q;
`else
   assign repeat_pulse = 1'b0;
`endif

   assign click      = click_q;
   assign dbl_click  = dbl_q;
   assign long_press = long_q;
   assign busy       = (state_q != KS_IDLE);

endmodule

// File: tb/tb_key_event.sv
// Scenario bench for key_event: per-step expected output vectors are queued from an
// event timeline when a scenario is planned and popped as each clock's outputs appear.
module tb_key_event;

   localparam int MAXN = 64;
   localparam logic [6:0] M_PRESS = 7'h01;
   localparam logic [6:0] M_REL   = 7'h02;
   localparam logic [6:0] M_CLICK = 7'h04;
   localparam logic [6:0] M_DBL   = 7'h08;
   localparam logic [6:0] M_LONG  = 7'h10;
   localparam logic [6:0] M_REP   = 7'h20;
   localparam logic [6:0] M_BUSY  = 7'h40;

   logic clk = 1'b0;
   logic rst;
   logic key_level;
   logic press_pulse, release_pulse, click, dbl_click, long_press, repeat_pulse, busy;

   always #5 clk = ~clk;

   key_event #(
      .LONG_CYC    (20),
      .DBL_GAP_CYC (10),
      .REPEAT_CYC  (5)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .key_level     (key_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .click         (click),
      .dbl_click     (dbl_click),
      .long_press    (long_press),
      .repeat_pulse  (repeat_pulse),
      .busy          (busy)
   );

   int total = 0;
   int bad   = 0;

   logic       lvl_a [MAXN];
   logic       rst_a [MAXN];
   logic [6:0] exp_a [MAXN];
   logic [6:0] exp_q [$];

   task automatic plan_clear();
      for (int i = 0; i < MAXN; i++) begin
         lvl_a[i] = 1'b0;
         rst_a[i] = 1'b0;
         exp_a[i] = '0;
      end
      exp_q.delete();
   endtask

   task automatic plan_key(input int a, input int b);
      for (int i = a; i <= b; i++) lvl_a[i] = 1'b1;
   endtask

   task automatic plan_rst(input int a, input int b);
      for (int i = a; i <= b; i++) rst_a[i] = 1'b1;
   endtask

   task automatic plan_ev(input int s, input logic [6:0] m);
      exp_a[s] = exp_a[s] | m;
   endtask

   task automatic plan_busy(input int a, input int b);
      for (int i = a; i <= b; i++) exp_a[i] = exp_a[i] | M_BUSY;
   endtask

   task automatic plan_commit(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(exp_a[i]);
   endtask

   // Drive one step's inputs, let one rising edge sample them, then read outputs mid-cycle.
   task automatic step(input logic lvl, input logic r, output logic [6:0] obs);
      key_level = lvl;
      rst       = r;
      @(posedge clk);
      @(negedge clk);
      obs = {busy, repeat_pulse, long_press, dbl_click, click, release_pulse, press_pulse};
   endtask

   task automatic test_reset();
      logic [6:0] obs, want;
      plan_clear();
      plan_rst(0, 2);
      plan_ev(3, M_REL);
      plan_commit(8);
      for (int i = 0; i < 8; i++) begin
         step(lvl_a[i], rst_a[i], obs);
         want = exp_q.pop_front();
         total++;
         if (obs !== want) begin
            bad++;
            $display("FAIL reset step=%0d got=%b want=%b", i, obs, want);
         end
      end
   endtask

   task automatic test_single();
      logic [6:0] obs, want;
      plan_clear();
      plan_key(2, 6);
      plan_ev(2, M_PRESS);
      plan_ev(7, M_REL);
      plan_ev(17, M_CLICK);
      plan_busy(2, 16);
      plan_commit(24);
      for (int i = 0; i < 24; i++) begin
         step(lvl_a[i], rst_a[i], obs);
         want = exp_q.pop_front();
         total++;
         if (obs !== want) begin
            bad++;
            $display("FAIL single step=%0d got=%b want=%b", i, obs, want);
         end
      end
   endtask

   task automatic test_double();
      logic [6:0] obs, want;
      plan_clear();
      plan_key(2, 6);
      plan_key(11, 15);
      plan_ev(2, M_PRESS);
      plan_ev(7, M_REL);
      plan_ev(11, M_PRESS);
      plan_ev(16, M_REL | M_DBL);
      plan_busy(2, 15);
      plan_commit(30);
      for (int i = 0; i < 30; i++) begin
         step(lvl_a[i], rst_a[i], obs);
         want = exp_q.pop_front();
         total++;
         if (obs !== want) begin
            bad++;
            $display("FAIL double step=%0d got=%b want=%b", i, obs, want);
         end
      end
   endtask

   task automatic test_long();
      logic [6:0] obs, want;
      plan_clear();
      plan_key(2, 34);
      plan_ev(2, M_PRESS);
      plan_ev(22, M_LONG);
`ifdef KEY_EVENT_REPEAT_EN
      plan_ev(27, M_REP);
      plan_ev(32, M_REP);
`endif
      plan_ev(35, M_REL);
      plan_busy(2, 34);
      plan_commit(50);
      for (int i = 0; i < 50; i++) begin
         step(lvl_a[i], rst_a[i], obs);
         want = exp_q.pop_front();
         total++;
         if (obs !== want) begin
            bad++;
            $display("FAIL long step=%0d got=%b want=%b", i, obs, want);
         end
      end
   endtask

   task automatic test_boundary_long();
      logic [6:0] obs, want;
      plan_clear();
      plan_key(2, 21);
      plan_ev(2, M_PRESS);
      plan_ev(22, M_REL);
      plan_ev(32, M_CLICK);
      plan_busy(2, 31);
      plan_commit(36);
      for (int i = 0; i < 36; i++) begin
         step(lvl_a[i], rst_a[i], obs);
         want = exp_q.pop_front();
         total++;
         if (obs !== want) begin
            bad++;
            $display("FAIL edge_long step=%0d got=%b want=%b", i, obs, want);
         end
      end
   endtask

   task automatic test_boundary_gap();
      logic [6:0] obs, want;
      plan_clear();
      plan_key(2, 6);
      plan_key(17, 21);
      plan_ev(2, M_PRESS);
      plan_ev(7, M_REL);
      plan_ev(17, M_PRESS);
      plan_ev(22, M_REL | M_DBL);
      plan_busy(2, 21);
      plan_commit(36);
      for (int i = 0; i < 36; i++) begin
         step(lvl_a[i], rst_a[i], obs);
         want = exp_q.pop_front();
         total++;
         if (obs !== want) begin
            bad++;
            $display("FAIL edge_gap step=%0d got=%b want=%b", i, obs, want);
         end
      end
   endtask

   task automatic test_reset_held();
      logic [6:0] obs, want;
      plan_clear();
      plan_rst(0, 2);
      plan_key(0, 7);
      plan_ev(8, M_REL);
      plan_commit(20);
      for (int i = 0; i < 20; i++) begin
         step(lvl_a[i], rst_a[i], obs);
         want = exp_q.pop_front();
         total++;
         if (obs !== want) begin
            bad++;
            $display("FAIL held_rst step=%0d got=%b want=%b", i, obs, want);
         end
      end
   endtask

   task automatic test_reset_wait2();
      logic [6:0] obs, want;
      plan_clear();
      plan_key(2, 6);
      plan_rst(10, 10);
      plan_ev(2, M_PRESS);
      plan_ev(7, M_REL);
      plan_busy(2, 9);
      plan_ev(11, M_REL);
      plan_commit(30);
      for (int i = 0; i < 30; i++) begin
         step(lvl_a[i], rst_a[i], obs);
         want = exp_q.pop_front();
         total++;
         if (obs !== want) begin
            bad++;
            $display("FAIL wait2_rst step=%0d got=%b want=%b", i, obs, want);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      key_level = 1'b0;
      test_reset();
      test_single();
      test_double();
      test_long();
      test_boundary_long();
      test_boundary_gap();
      test_reset_held();
      test_reset_wait2();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
